// File: rtl/lookup_table_write_pkg.sv
// Shared constants and the bank-aware address composition used by the
// fill and drain sides of lookup_table_write.
package lookup_table_write_pkg;

    localparam int SIZE_W     = 16;
    localparam int AXI_DATA_W = 32;
    localparam int ADDR_W     = 12;
    localparam int DIFF       = AXI_DATA_W / SIZE_W;
    localparam int LANE_W     = (DIFF > 1) ? $clog2(DIFF) : 1;

    // With ping-pong enabled the table MSB selects the bank and the offset wraps below it.
    function automatic logic [ADDR_W-1:0] bank_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] idx,
        input logic              pp,
        input logic              bank
    );
        logic [ADDR_W-1:0] sum;
        sum = base + idx;
        if (pp) begin
            bank_addr = {bank, sum[ADDR_W-2:0]};
        end else begin
            bank_addr = sum;
        end
    endfunction

endpackage

// File: rtl/lookup_table_write_memory_reader.sv
// Drain side: walks table words through a 1-cycle-latency read port into a
// 2-entry FIFO whose head is presented as a valid/ready stream.
module memory_reader
    import lookup_table_write_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [ADDR_W-1:0]     base_i,
    input  logic                  pp_i,
    input  logic                  bank_i,
    output logic                  rd_en_o,
    output logic [ADDR_W-1:0]     rd_addr_o,
    input  logic [AXI_DATA_W-1:0] rd_data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [AXI_DATA_W-1:0] data_o
);

    logic [LEN_W-1:0]                remain_q, remain_d;
    logic [ADDR_W-1:0]               idx_q, idx_d;
    logic [ADDR_W-1:0]               base_q, base_d;
    logic                            pp_q, pp_d;
    logic                            bank_q, bank_d;
    logic                            pend_q, pend_d;
    logic [1:0][AXI_DATA_W-1:0]      fifo_q, fifo_d;
    logic                            wptr_q, wptr_d;
    logic                            rptr_q, rptr_d;
    logic [1:0]                      cnt_q, cnt_d;
    logic                            pop_s;
    logic                            rd_en_s;

    assign valid_o   = (cnt_q != 2'd0);
    assign data_o    = fifo_q[rptr_q];
    assign pop_s     = valid_o & ready_i;
    // A read may issue whenever the FIFO plus the in-flight word still fit after this cycle's pop.
    assign rd_en_s   = !start_i && (remain_q != {LEN_W{1'b0}}) &&
                       (({1'b0, cnt_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop_s}));
    assign rd_en_o   = rd_en_s;
    assign rd_addr_o = bank_addr(base_q, idx_q, pp_q, bank_q);

    // Next-state for the read counter, in-flight flag and FIFO.
    always_comb begin
        remain_d = remain_q;
        idx_d    = idx_q;
        base_d   = base_q;
        pp_d     = pp_q;
        bank_d   = bank_q;
        pend_d   = rd_en_s;
        fifo_d   = fifo_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            remain_d = len_i;
            idx_d    = {ADDR_W{1'b0}};
            base_d   = base_i;
            pp_d     = pp_i;
            bank_d   = bank_i;
            pend_d   = 1'b0;
            wptr_d   = 1'b0;
            rptr_d   = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (rd_en_s) begin
                remain_d = remain_q - LEN_W'(1);
                idx_d    = idx_q + ADDR_W'(1);
            end else begin
                remain_d = remain_q;
            end
            if (pend_q) begin
                fifo_d[wptr_q] = rd_data_i;
                wptr_d         = ~wptr_q;
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = ~rptr_q;
            end else begin
                rptr_d = rptr_q;
            end
            cnt_d = cnt_q + {1'b0, pend_q} - {1'b0, pop_s};
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain_q <= {LEN_W{1'b0}};
            idx_q    <= {ADDR_W{1'b0}};
            base_q   <= {ADDR_W{1'b0}};
            pp_q     <= 1'b0;
            bank_q   <= 1'b0;
            pend_q   <= 1'b0;
            fifo_q   <= {(2*AXI_DATA_W){1'b0}};
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            remain_q <= remain_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            pp_q     <= pp_d;
            bank_q   <= bank_d;
            pend_q   <= pend_d;
            fifo_q   <= fifo_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/lookup_table_write.sv
// Versat unit: packs datapath elements into table words (fill) and streams
// table words out as a databus write burst (drain), optionally ping-ponging banks.
module lookup_table_write
    import lookup_table_write_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int AXI_ADDR_W = 32,
    parameter int LEN_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    running,
    input  logic                    disabled,
    output logic                    done,
    input  logic [DATA_W-1:0]       in0,
    output logic                    databus_valid_0,
    input  logic                    databus_ready_0,
    output logic [AXI_ADDR_W-1:0]   databus_addr_0,
    input  logic [AXI_DATA_W-1:0]   databus_rdata_0,
    output logic [AXI_DATA_W-1:0]   databus_wdata_0,
    output logic [AXI_DATA_W/8-1:0] databus_wstrb_0,
    output logic [LEN_W-1:0]        databus_len_0,
    input  logic                    databus_last_0,
    output logic [ADDR_W-1:0]       ext_dp_addr_0_port_0,
    output logic [AXI_DATA_W-1:0]   ext_dp_out_0_port_0,
    input  logic [AXI_DATA_W-1:0]   ext_dp_in_0_port_0,
    output logic                    ext_dp_enable_0_port_0,
    output logic                    ext_dp_write_0_port_0,
    output logic [ADDR_W-1:0]       ext_dp_addr_0_port_1,
    output logic [AXI_DATA_W-1:0]   ext_dp_out_0_port_1,
    input  logic [AXI_DATA_W-1:0]   ext_dp_in_0_port_1,
    output logic                    ext_dp_enable_0_port_1,
    output logic                    ext_dp_write_0_port_1,
    input  logic [AXI_ADDR_W-1:0]   ext_addr,
    input  logic [ADDR_W-1:0]       int_addr,
    input  logic [31:0]             size,
    input  logic [LEN_W-1:0]        length,
    input  logic                    pingPong,
    input  logic [31:0]             delay0
);

    logic                  done_q, done_d;
    logic [AXI_ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic                  pp_state_q, pp_state_d;
    logic [31:0]           delay_q, delay_d;
    logic [31:0]           elem_q, elem_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [ADDR_W-1:0]     widx_q, widx_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic                  fpp_q, fpp_d;
    logic                  fbank_q, fbank_d;
    logic [AXI_DATA_W-1:0] pack_q, pack_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [AXI_DATA_W-1:0] wr_data_q, wr_data_d;
    logic                  start_s;
    logic                  capture_s;
    logic                  beat_last_s;
    logic [AXI_DATA_W-1:0] elem_s;
    logic [AXI_DATA_W-1:0] word_s;
    logic                  rd_valid_s;
    logic                  unused_s;

    assign start_s     = run & ~disabled;
    assign capture_s   = running & ~disabled;
    assign beat_last_s = rd_valid_s & databus_ready_0 & databus_last_0;
    assign elem_s      = AXI_DATA_W'(in0[SIZE_W-1:0]);
    // Lanes above lane_q are still zero, so OR-insertion also zero-fills a partial flush.
    assign word_s      = pack_q | (elem_s << (lane_q * SIZE_W));
    assign unused_s    = ^{databus_rdata_0, ext_dp_in_0_port_0, in0};

    // Run control, done flag, bank toggle and burst address.
    always_comb begin
        done_d     = done_q;
        bus_addr_d = bus_addr_q;
        pp_state_d = pp_state_q;
        if (run) begin
            pp_state_d = pingPong & ~pp_state_q;
        end else begin
            pp_state_d = pp_state_q;
        end
        if (start_s) begin
            done_d     = (length == {LEN_W{1'b0}});
            bus_addr_d = ext_addr;
        end else if (beat_last_s) begin
            done_d = 1'b1;
        end else begin
            done_d = done_q;
        end
    end

    // Fill engine: delay, per-element lane packing and word write-out.
    always_comb begin
        delay_d   = delay_q;
        elem_d    = elem_q;
        lane_d    = lane_q;
        widx_d    = widx_q;
        base_d    = base_q;
        fpp_d     = fpp_q;
        fbank_d   = fbank_q;
        pack_d    = pack_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (start_s) begin
            delay_d = delay0;
            elem_d  = size;
            lane_d  = {LANE_W{1'b0}};
            widx_d  = {ADDR_W{1'b0}};
            base_d  = int_addr;
            fpp_d   = pingPong;
            fbank_d = pingPong & ~pp_state_q;
            pack_d  = {AXI_DATA_W{1'b0}};
        end else if (capture_s && (delay_q != 32'd0)) begin
            delay_d = delay_q - 32'd1;
        end else if (capture_s && (elem_q != 32'd0)) begin
            elem_d = elem_q - 32'd1;
            if ((lane_q == LANE_W'(DIFF - 1)) || (elem_q == 32'd1)) begin
                wr_en_d   = 1'b1;
                wr_data_d = word_s;
                wr_addr_d = bank_addr(base_q, widx_q, fpp_q, fbank_q);
                widx_d    = widx_q + ADDR_W'(1);
                lane_d    = {LANE_W{1'b0}};
                pack_d    = {AXI_DATA_W{1'b0}};
            end else begin
                pack_d = word_s;
                lane_d = lane_q + LANE_W'(1);
            end
        end else begin
            delay_d = delay_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q     <= 1'b1;
            bus_addr_q <= {AXI_ADDR_W{1'b0}};
            pp_state_q <= 1'b0;
            delay_q    <= 32'd0;
            elem_q     <= 32'd0;
            lane_q     <= {LANE_W{1'b0}};
            widx_q     <= {ADDR_W{1'b0}};
            base_q     <= {ADDR_W{1'b0}};
            fpp_q      <= 1'b0;
            fbank_q    <= 1'b0;
            pack_q     <= {AXI_DATA_W{1'b0}};
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {ADDR_W{1'b0}};
            wr_data_q  <= {AXI_DATA_W{1'b0}};
        end else begin
            done_q     <= done_d;
            bus_addr_q <= bus_addr_d;
            pp_state_q <= pp_state_d;
            delay_q    <= delay_d;
            elem_q     <= elem_d;
            lane_q     <= lane_d;
            widx_q     <= widx_d;
            base_q     <= base_d;
            fpp_q      <= fpp_d;
            fbank_q    <= fbank_d;
            pack_q     <= pack_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    memory_reader #(.LEN_W(LEN_W)) u_reader (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_s),
        .len_i     (length),
        .base_i    (int_addr),
        .pp_i      (pingPong),
        .bank_i    (pingPong & pp_state_q),
        .rd_en_o   (ext_dp_enable_0_port_1),
        .rd_addr_o (ext_dp_addr_0_port_1),
        .rd_data_i (ext_dp_in_0_port_1),
        .valid_o   (rd_valid_s),
        .ready_i   (databus_ready_0),
        .data_o    (databus_wdata_0)
    );

    assign done                   = done_q;
    assign databus_valid_0        = rd_valid_s;
    assign databus_addr_0         = bus_addr_q;
    assign databus_wstrb_0        = rd_valid_s ? {(AXI_DATA_W/8){1'b1}} : {(AXI_DATA_W/8){1'b0}};
    assign databus_len_0          = length;
    assign ext_dp_addr_0_port_0   = wr_addr_q;
    assign ext_dp_out_0_port_0    = wr_data_q;
    assign ext_dp_enable_0_port_0 = wr_en_q;
    assign ext_dp_write_0_port_0  = 1'b1;
    assign ext_dp_out_0_port_1    = {AXI_DATA_W{1'b0}};
    assign ext_dp_write_0_port_1  = 1'b0;

endmodule

// File: tb/tb_lookup_table_write.sv
// Directed bench for lookup_table_write with a behavioural dual-port table.
module tb_lookup_table_write;

    logic        clk = 1'b0;
    logic        rst, run, running, disabled, done;
    logic [31:0] in0;
    logic        valid, ready, last;
    logic [31:0] bus_addr, rdata, wdata;
    logic [3:0]  wstrb;
    logic [7:0]  blen, length;
    logic [11:0] addr0, addr1, int_addr;
    logic [31:0] dout0, din0, dout1, rd1;
    logic        en0, wr0, en1, wr1;
    logic [31:0] ext_addr, size, delay0;
    logic        pingPong;

    logic [31:0] mem [0:4095];
    logic [31:0] beats [0:255];
    int nwr = 0, nbeats = 0, nvalid = 0;
    int burst_base = 0, exp_len = 0;
    int checks = 0, failures = 0;
    int base, w0, v0;
    logic [3:0] rpat;

    always #5 clk = ~clk;

    lookup_table_write dut (
        .clk(clk), .rst(rst), .run(run), .running(running), .disabled(disabled), .done(done),
        .in0(in0), .databus_valid_0(valid), .databus_ready_0(ready), .databus_addr_0(bus_addr),
        .databus_rdata_0(rdata), .databus_wdata_0(wdata), .databus_wstrb_0(wstrb),
        .databus_len_0(blen), .databus_last_0(last),
        .ext_dp_addr_0_port_0(addr0), .ext_dp_out_0_port_0(dout0), .ext_dp_in_0_port_0(din0),
        .ext_dp_enable_0_port_0(en0), .ext_dp_write_0_port_0(wr0),
        .ext_dp_addr_0_port_1(addr1), .ext_dp_out_0_port_1(dout1), .ext_dp_in_0_port_1(rd1),
        .ext_dp_enable_0_port_1(en1), .ext_dp_write_0_port_1(wr1),
        .ext_addr(ext_addr), .int_addr(int_addr), .size(size), .length(length),
        .pingPong(pingPong), .delay0(delay0)
    );

    assign din0 = 32'h0;
    assign last = valid && ((nbeats - burst_base) == (exp_len - 1));

    always @(posedge clk) begin
        if (en0 && wr0) mem[addr0] <= dout0;
        if (en1) rd1 <= mem[addr1];
    end

    always @(posedge clk) begin
        if (en0) nwr <= nwr + 1;
        if (valid) nvalid <= nvalid + 1;
        if (valid && ready) begin
            beats[nbeats & 255] <= wdata;
            nbeats <= nbeats + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; running = 1'b1; disabled = 1'b0; in0 = 32'h0;
        ready = 1'b0; rdata = 32'h0; ext_addr = 32'h0; int_addr = 12'h0;
        size = 32'd0; length = 8'd0; pingPong = 1'b0; delay0 = 32'd0;
        tick(); tick();
        chk("rst_done", {31'd0, done}, 32'd1);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_en0", {31'd0, en0}, 32'd0);
        chk("rst_en1", {31'd0, en1}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
        rst = 1'b0;
        tick();

        // Fill 1,2,3,4 into words 0x010/0x011, no drain.
        int_addr = 12'h010; size = 32'd4; length = 8'd0;
        do_run();
        chk("fill_len0_done", {31'd0, done}, 32'd1);
        in0 = 32'd1; tick();
        in0 = 32'd2; tick();
        chk("fill_w0_en", {31'd0, en0}, 32'd1);
        chk("fill_w0_addr", {20'd0, addr0}, 32'h010);
        chk("fill_w0_data", dout0, 32'h00020001);
        in0 = 32'd3; tick();
        in0 = 32'd4; tick();
        in0 = 32'd0; tick(); tick(); tick();
        chk("fill_mem10", mem[12'h010], 32'h00020001);
        chk("fill_mem11", mem[12'h011], 32'h00040003);

        // Drain those two words.
        w0 = nwr; size = 32'd0; length = 8'd2; ready = 1'b1; ext_addr = 32'hA000_0000;
        burst_base = nbeats; exp_len = 2; base = nbeats;
        do_run();
        chk("drain_done_low", {31'd0, done}, 32'd0);
        chk("drain_busaddr", bus_addr, 32'hA000_0000);
        chk("drain_len", {24'd0, blen}, 32'd2);
        wait_done("drain2_done", 20);
        chk("drain2_b0", beats[base & 255], 32'h00020001);
        chk("drain2_b1", beats[(base + 1) & 255], 32'h00040003);
        tick();
        chk("drain2_count", nbeats - base, 32'd2);
        chk("drain2_nowrite", nwr - w0, 32'd0);

        // size=3 with delay0=2: zero-filled partial flush, upper input bits ignored.
        int_addr = 12'h020; size = 32'd3; length = 8'd0; delay0 = 32'd2;
        w0 = nwr;
        do_run();
        in0 = 32'h0000DEAD; tick();
        in0 = 32'h0000DEAD; tick();
        in0 = 32'hFFFF0001; tick();
        in0 = 32'd2; tick();
        in0 = 32'd3; tick();
        in0 = 32'h0000BEEF; tick(); tick(); tick();
        chk("size3_mem20", mem[12'h020], 32'h00020001);
        chk("size3_mem21", mem[12'h021], 32'h00000003);
        chk("size3_nwr", nwr - w0, 32'd2);
        delay0 = 32'd0;

        // 16 elements into 8 words at 0x040, then drain with ready 1,0,0,1.
        int_addr = 12'h040; size = 32'd16; length = 8'd0;
        do_run();
        for (int k = 0; k < 16; k++) begin
            in0 = k + 1;
            tick();
        end
        in0 = 32'd0; tick(); tick(); tick();
        size = 32'd0; length = 8'd8; burst_base = nbeats; exp_len = 8; base = nbeats;
        rpat = 4'b1001;
        do_run();
        for (int c = 0; c < 80 && done !== 1'b1; c++) begin
            ready = rpat[c % 4];
            tick();
        end
        chk("drain8_done", {31'd0, done}, 32'd1);
        tick();
        chk("drain8_count", nbeats - base, 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain8_b%0d", k), beats[(base + k) & 255],
                ((2 * k + 2) << 16) | (2 * k + 1));
        end

        // Reset in the middle of a ping-pong burst.
        ready = 1'b0; pingPong = 1'b1; ext_addr = 32'h0000_5000; length = 8'd8;
        burst_base = nbeats; exp_len = 8;
        do_run();
        tick(); tick(); tick();
        chk("midrst_valid_before", {31'd0, valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_done", {31'd0, done}, 32'd1);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_addr", bus_addr, 32'd0);

        // Ping-pong run 1: fills bank MSB=1, drains stale bank 0.
        int_addr = 12'h100; size = 32'd2; length = 8'd1; ready = 1'b1;
        burst_base = nbeats; exp_len = 1;
        do_run();
        in0 = 32'h11; tick();
        in0 = 32'h22; tick();
        in0 = 32'd0;
        wait_done("pp1_done", 20);
        tick(); tick(); tick();
        chk("pp1_fill_bank1", mem[12'h900], 32'h00220011);

        // Run 2: drains bank 1, fills bank 0.
        burst_base = nbeats; exp_len = 1; base = nbeats;
        do_run();
        in0 = 32'h33; tick();
        in0 = 32'h44; tick();
        in0 = 32'd0;
        wait_done("pp2_done", 20);
        tick(); tick(); tick();
        chk("pp2_drain_bank1", beats[base & 255], 32'h00220011);
        chk("pp2_fill_bank0", mem[12'h100], 32'h00440033);

        // Run 3: drains bank 0.
        size = 32'd0; burst_base = nbeats; exp_len = 1; base = nbeats;
        do_run();
        wait_done("pp3_done", 20);
        tick();
        chk("pp3_drain_bank0", beats[base & 255], 32'h00440033);

        // length=0: done immediately, no beats.
        pingPong = 1'b0; int_addr = 12'h010; length = 8'd0; v0 = nvalid;
        do_run();
        chk("len0_done", {31'd0, done}, 32'd1);
        tick(); tick(); tick(); tick();
        chk("len0_novalid", nvalid - v0, 32'd0);

        // disabled run: nothing happens.
        disabled = 1'b1; size = 32'd2; length = 8'd2; w0 = nwr; v0 = nvalid;
        do_run();
        chk("dis_done_run", {31'd0, done}, 32'd1);
        in0 = 32'd5; tick();
        in0 = 32'd6; tick();
        tick(); tick(); tick(); tick();
        chk("dis_nowrite", nwr - w0, 32'd0);
        chk("dis_novalid", nvalid - v0, 32'd0);
        chk("dis_done", {31'd0, done}, 32'd1);
        disabled = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
